// File: rtl/nim_trig_pkg.sv
// Shared types and default widths for the NIM trigger matrix.
// Channel configuration and state encodings live here so the top and channel agree.
package nim_trig_pkg;

    localparam int unsigned DEF_N_IN       = 12;
    localparam int unsigned DEF_N_OUT      = 4;
    localparam int unsigned DEF_CNT_W      = 32;
    localparam int unsigned DEF_STRETCH_W  = 8;
    localparam int unsigned DEF_PRESCALE_W = 16;
    localparam int unsigned DEF_DEAD_W     = 16;
    localparam int unsigned DEF_THR_W      = $clog2(DEF_N_IN + 1);

    typedef enum logic [1:0] {
        MODE_OR  = 2'd0,
        MODE_AND = 2'd1,
        MODE_MAJ = 2'd2,
        MODE_DIS = 2'd3
    } trig_mode_t;

    // Legacy state codes, kept so existing decode logic and probes still line up
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_DEAD  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        PULSE = ST_PULSE,
        DEAD  = ST_DEAD
    } trig_state_t;

    typedef struct packed {
        logic [DEF_N_IN-1:0]       mask;
        logic [DEF_N_IN-1:0]       veto_mask;
        trig_mode_t                mode;
        logic [DEF_THR_W-1:0]      threshold;
        logic [DEF_PRESCALE_W-1:0] prescale;
        logic [DEF_STRETCH_W-1:0]  stretch;
        logic [DEF_DEAD_W-1:0]     deadtime;
        logic                      out_invert;
    } chan_cfg_t;

endpackage

// File: rtl/nim_trigger_channel.sv
// One trigger output channel: condition, rising-edge candidate, prescaler,
// pulse/dead FSM and the three saturating counters.
module nim_trigger_channel
    import nim_trig_pkg::*;
#(
    parameter int unsigned N_IN       = DEF_N_IN,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned STRETCH_W  = DEF_STRETCH_W,
    parameter int unsigned PRESCALE_W = DEF_PRESCALE_W,
    parameter int unsigned DEAD_W     = DEF_DEAD_W,
    localparam int unsigned THR_W     = $clog2(N_IN + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_IN-1:0]       in_q,
    input  logic [N_IN-1:0]       mask,
    input  logic [N_IN-1:0]       veto_mask,
    input  logic [1:0]            mode,
    input  logic [THR_W-1:0]      threshold,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [STRETCH_W-1:0]  stretch,
    input  logic [DEAD_W-1:0]     deadtime,
    input  logic                  reset_cnt,
    output logic                  pulse_q,
    output logic [CNT_W-1:0]      count_raw,
    output logic [CNT_W-1:0]      count_acc,
    output logic [CNT_W-1:0]      count_lost
);

    trig_state_t           state;
    logic [N_IN-1:0]       sel;
    logic [THR_W-1:0]      pop;
    logic                  cond;
    logic                  cond_d;
    logic                  veto;
    logic                  cand;
    logic                  pre_hit;
    logic [PRESCALE_W-1:0] pre_cnt;
    logic [STRETCH_W-1:0]  width_cnt;
    logic [DEAD_W-1:0]     dead_cnt;

    assign sel = in_q & mask;

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            pop = pop + THR_W'(sel[i]);
        end
    end

    always_comb begin
        cond = 1'b0;
        case (trig_mode_t'(mode))
            MODE_OR:  cond = (pop != '0);
            MODE_AND: cond = (sel == mask) && (mask != '0);
            MODE_MAJ: cond = (threshold != '0) && (pop >= threshold);
            default:  cond = 1'b0;
        endcase
    end

    assign veto = |(in_q & veto_mask);
    assign cand = cond & ~cond_d & ~veto;
    // >= rather than == so a prescale lowered below pre_cnt accepts the next candidate
    assign pre_hit = (pre_cnt >= prescale);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pulse_q   <= 1'b0;
            cond_d    <= 1'b0;
            width_cnt <= '0;
            dead_cnt  <= '0;
        end else begin
            cond_d <= cond;
            case (state)
                IDLE: begin
                    if (cand && pre_hit) begin
                        state     <= PULSE;
                        pulse_q   <= 1'b1;
                        width_cnt <= stretch;
                    end
                end
                PULSE: begin
                    if (width_cnt == '0) begin
                        pulse_q <= 1'b0;
                        if (deadtime != '0) begin
                            state    <= DEAD;
                            dead_cnt <= deadtime;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        width_cnt <= width_cnt - STRETCH_W'(1);
                    end
                end
                DEAD: begin
                    if (dead_cnt <= DEAD_W'(1)) begin
                        state <= IDLE;
                    end else begin
                        dead_cnt <= dead_cnt - DEAD_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    pulse_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt    <= '0;
            count_raw  <= '0;
            count_acc  <= '0;
            count_lost <= '0;
        end else if (reset_cnt) begin
            pre_cnt    <= '0;
            count_raw  <= '0;
            count_acc  <= '0;
            count_lost <= '0;
        end else if (cand) begin
            if (count_raw != '1) count_raw <= count_raw + CNT_W'(1);
            if (state == IDLE) begin
                if (pre_hit) begin
                    pre_cnt <= '0;
                    if (count_acc != '1) count_acc <= count_acc + CNT_W'(1);
                end else begin
                    pre_cnt <= pre_cnt + PRESCALE_W'(1);
                end
            end else begin
                if (count_lost != '1) count_lost <= count_lost + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/nim_trigger_matrix.sv
// Programmable trigger matrix: registers the conditioned inputs once and fans
// them out to N_OUT independent trigger channels.
module nim_trigger_matrix
    import nim_trig_pkg::*;
#(
    parameter int unsigned N_IN       = DEF_N_IN,
    parameter int unsigned N_OUT      = DEF_N_OUT,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned STRETCH_W  = DEF_STRETCH_W,
    parameter int unsigned PRESCALE_W = DEF_PRESCALE_W,
    parameter int unsigned DEAD_W     = DEF_DEAD_W
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [N_IN-1:0]                      inputs,
    input  logic [N_OUT*N_IN-1:0]                mask,
    input  logic [N_OUT*N_IN-1:0]                veto_mask,
    input  logic [N_OUT*2-1:0]                   mode,
    input  logic [N_OUT*$clog2(N_IN+1)-1:0]      threshold,
    input  logic [N_OUT*PRESCALE_W-1:0]          prescale,
    input  logic [N_OUT*STRETCH_W-1:0]           stretch,
    input  logic [N_OUT*DEAD_W-1:0]              deadtime,
    input  logic [N_OUT-1:0]                     out_invert,
    input  logic                                 reset_cnt,
    output logic [N_OUT-1:0]                     dout,
    output logic [N_OUT*CNT_W-1:0]               count_raw,
    output logic [N_OUT*CNT_W-1:0]               count_acc,
    output logic [N_OUT*CNT_W-1:0]               count_lost
);

    localparam int unsigned THR_W = $clog2(N_IN + 1);

    logic [N_IN-1:0]  in_q;
    logic [N_OUT-1:0] pulse_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_q <= '0;
        end else begin
            in_q <= inputs;
        end
    end

    for (genvar o = 0; o < N_OUT; o++) begin : g_chan
        nim_trigger_channel #(
            .N_IN       (N_IN),
            .CNT_W      (CNT_W),
            .STRETCH_W  (STRETCH_W),
            .PRESCALE_W (PRESCALE_W),
            .DEAD_W     (DEAD_W)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .in_q       (in_q),
            .mask       (mask[o*N_IN +: N_IN]),
            .veto_mask  (veto_mask[o*N_IN +: N_IN]),
            .mode       (mode[o*2 +: 2]),
            .threshold  (threshold[o*THR_W +: THR_W]),
            .prescale   (prescale[o*PRESCALE_W +: PRESCALE_W]),
            .stretch    (stretch[o*STRETCH_W +: STRETCH_W]),
            .deadtime   (deadtime[o*DEAD_W +: DEAD_W]),
            .reset_cnt  (reset_cnt),
            .pulse_q    (pulse_q[o]),
            .count_raw  (count_raw[o*CNT_W +: CNT_W]),
            .count_acc  (count_acc[o*CNT_W +: CNT_W]),
            .count_lost (count_lost[o*CNT_W +: CNT_W])
        );
    end

    assign dout = pulse_q ^ out_invert;

endmodule

// File: tb/tb_nim_trigger_matrix.sv
// Self-checking bench for nim_trigger_matrix: directed scenarios plus a randomized
// run, all checked against a cycle-window reference model of the trigger rules.
module tb_nim_trigger_matrix;

    localparam int NI = 12;
    localparam int NO = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NI-1:0]     inputs = '0;
    logic [NO*NI-1:0]  mask;
    logic [NO*NI-1:0]  veto_mask;
    logic [NO*2-1:0]   mode;
    logic [NO*4-1:0]   threshold;
    logic [NO*16-1:0]  prescale;
    logic [NO*8-1:0]   stretch;
    logic [NO*16-1:0]  deadtime;
    logic [NO-1:0]     out_invert;
    logic              reset_cnt = 1'b0;
    logic [NO-1:0]     dout;
    logic [NO*32-1:0]  count_raw;
    logic [NO*32-1:0]  count_acc;
    logic [NO*32-1:0]  count_lost;

    // configuration as seen by both the bench model and the DUT
    logic [NI-1:0] c_mask [NO];
    logic [NI-1:0] c_veto [NO];
    logic [1:0]    c_mode [NO];
    logic [3:0]    c_thr  [NO];
    logic [15:0]   c_pre  [NO];
    logic [7:0]    c_str  [NO];
    logic [15:0]   c_dead [NO];
    logic          c_inv  [NO];

    // reference model state
    longint        cyc;
    logic [NI-1:0] m_in_q;
    bit            m_cond_d [NO];
    int unsigned   m_raw  [NO];
    int unsigned   m_acc  [NO];
    int unsigned   m_lost [NO];
    int unsigned   m_pre  [NO];
    longint        ps [NO];
    longint        pe [NO];
    longint        free_at [NO];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always_comb begin
        mask = '0; veto_mask = '0; mode = '0; threshold = '0;
        prescale = '0; stretch = '0; deadtime = '0; out_invert = '0;
        for (int o = 0; o < NO; o++) begin
            mask[o*NI +: NI]      = c_mask[o];
            veto_mask[o*NI +: NI] = c_veto[o];
            mode[o*2 +: 2]        = c_mode[o];
            threshold[o*4 +: 4]   = c_thr[o];
            prescale[o*16 +: 16]  = c_pre[o];
            stretch[o*8 +: 8]     = c_str[o];
            deadtime[o*16 +: 16]  = c_dead[o];
            out_invert[o]         = c_inv[o];
        end
    end

    nim_trigger_matrix #(
        .N_IN(NI), .N_OUT(NO), .CNT_W(32), .STRETCH_W(8), .PRESCALE_W(16), .DEAD_W(16)
    ) dut (
        .clk(clk), .reset(reset), .inputs(inputs), .mask(mask), .veto_mask(veto_mask),
        .mode(mode), .threshold(threshold), .prescale(prescale), .stretch(stretch),
        .deadtime(deadtime), .out_invert(out_invert), .reset_cnt(reset_cnt),
        .dout(dout), .count_raw(count_raw), .count_acc(count_acc), .count_lost(count_lost)
    );

    function automatic bit m_cond(int o, logic [NI-1:0] x);
        logic [NI-1:0] s;
        int p;
        s = x & c_mask[o];
        p = $countones(s);
        case (c_mode[o])
            2'd0:    return p >= 1;
            2'd1:    return (c_mask[o] != 0) && (s == c_mask[o]);
            2'd2:    return (c_thr[o] != 0) && (p >= int'(c_thr[o]));
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_clear();
        m_in_q = '0;
        for (int o = 0; o < NO; o++) begin
            m_cond_d[o] = 0; m_raw[o] = 0; m_acc[o] = 0; m_lost[o] = 0; m_pre[o] = 0;
            ps[o] = 1; pe[o] = 0; free_at[o] = 0;
        end
    endtask

    // One clock edge of the reference: a candidate seen during the previous cycle
    // is accepted if the channel is free and the prescaler has reached its target.
    task automatic model_edge();
        bit c, v, cand, idle, hit;
        cyc++;
        for (int o = 0; o < NO; o++) begin
            c = m_cond(o, m_in_q);
            v = |(m_in_q & c_veto[o]);
            cand = c && !m_cond_d[o] && !v;
            if (cand) begin
                idle = (cyc >= free_at[o]);
                hit  = idle && (m_pre[o] >= int'(c_pre[o]));
                if (hit) begin
                    ps[o] = cyc;
                    pe[o] = cyc + longint'(c_str[o]);
                    free_at[o] = cyc + longint'(c_str[o]) + 2 + longint'(c_dead[o]);
                end
                if (!reset_cnt) begin
                    m_raw[o]++;
                    if (!idle) m_lost[o]++;
                    else if (hit) begin m_acc[o]++; m_pre[o] = 0; end
                    else m_pre[o]++;
                end
            end
            if (reset_cnt) begin
                m_raw[o] = 0; m_acc[o] = 0; m_lost[o] = 0; m_pre[o] = 0;
            end
            m_cond_d[o] = c;
        end
        m_in_q = inputs;
    endtask

    task automatic step(input logic [NI-1:0] v, input bit rc = 0);
        logic e;
        @(negedge clk);
        for (int o = 0; o < NO; o++) begin
            e = ((cyc >= ps[o]) && (cyc <= pe[o])) ^ c_inv[o];
            n_checks++;
            if (dout[o] !== e) begin
                n_fail++;
                $display("FAIL dout[%0d] cycle %0d: got %b expected %b", o, cyc, dout[o], e);
            end
        end
        inputs = v;
        reset_cnt = rc;
        @(posedge clk);
        model_edge();
    endtask

    task automatic cfg_clear();
        for (int o = 0; o < NO; o++) begin
            c_mask[o] = '0; c_veto[o] = '0; c_mode[o] = 2'd3; c_thr[o] = '0;
            c_pre[o] = '0; c_str[o] = '0; c_dead[o] = '0; c_inv[o] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; inputs = '0; reset_cnt = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic check_cnt0(input string tag, input int unsigned raw, input int unsigned acc,
                              input int unsigned lost);
        n_checks++;
        if (count_raw[31:0] !== raw || count_acc[31:0] !== acc || count_lost[31:0] !== lost) begin
            n_fail++;
            $display("FAIL %s: got raw=%0d acc=%0d lost=%0d expected raw=%0d acc=%0d lost=%0d",
                     tag, count_raw[31:0], count_acc[31:0], count_lost[31:0], raw, acc, lost);
        end
    endtask

    task automatic test_reset();
        cfg_clear();
        c_inv[0] = 1'b1; c_inv[2] = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (dout !== 4'b0101 || count_raw !== '0 || count_acc !== '0 || count_lost !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got dout=%b raw=%h expected dout=0101 counters 0", dout, count_raw);
        end
        do_reset();
        for (int i = 0; i < 4; i++) step('0);
    endtask

    task automatic test_or_basic();
        int hi = 0;
        cfg_clear();
        c_mode[0] = 2'd0; c_mask[0] = 12'h001; c_str[0] = 8'd3;
        do_reset();
        step(12'h001);
        for (int i = 0; i < 10; i++) begin
            step('0);
            #1 if (dout[0]) hi++;
        end
        n_checks++;
        if (hi != 4) begin n_fail++; $display("FAIL or_width: got %0d cycles expected 4", hi); end
        check_cnt0("or_counts", 1, 1, 0);
    endtask

    task automatic test_majority();
        cfg_clear();
        c_mode[0] = 2'd2; c_mask[0] = 12'h00F; c_thr[0] = 4'd2; c_str[0] = 8'd1;
        do_reset();
        for (int i = 0; i < 5; i++) step(12'h001);
        check_cnt0("maj_below", 0, 0, 0);
        for (int i = 0; i < 50; i++) step(12'h005);
        check_cnt0("maj_held", 1, 1, 0);
        for (int i = 0; i < 4; i++) step('0);
    endtask

    task automatic test_prescale();
        int pulses = 0;
        logic last = 1'b0;
        cfg_clear();
        c_mode[0] = 2'd0; c_mask[0] = 12'h001; c_pre[0] = 16'd2; c_str[0] = 8'd2;
        do_reset();
        for (int t = 0; t < 9; t++) begin
            step(12'h001);
            for (int i = 0; i < 19; i++) begin
                step('0);
                #1 if (dout[0] && !last) pulses++;
                last = dout[0];
            end
        end
        n_checks++;
        if (pulses != 3) begin n_fail++; $display("FAIL prescale_pulses: got %0d expected 3", pulses); end
        check_cnt0("prescale_counts", 9, 3, 0);
    endtask

    task automatic test_deadtime();
        cfg_clear();
        c_mode[0] = 2'd0; c_mask[0] = 12'h001; c_str[0] = 8'd0; c_dead[0] = 16'd10;
        do_reset();
        step(12'h001);
        for (int i = 0; i < 4; i++) step('0);
        step(12'h001);
        for (int i = 0; i < 4; i++) step('0);
        check_cnt0("dead_lost", 2, 1, 1);
        step('0); step('0);
        step(12'h001);
        for (int i = 0; i < 15; i++) step('0);
        check_cnt0("dead_edge12", 3, 2, 1);
    endtask

    task automatic test_veto();
        cfg_clear();
        c_mode[0] = 2'd0; c_mask[0] = 12'h001; c_veto[0] = 12'h800; c_str[0] = 8'd1;
        do_reset();
        for (int i = 0; i < 3; i++) step(12'h801);
        for (int i = 0; i < 3; i++) step('0);
        check_cnt0("veto_block", 0, 0, 0);
        for (int i = 0; i < 3; i++) step(12'h001);
        for (int i = 0; i < 4; i++) step('0);
        check_cnt0("veto_low", 1, 1, 0);
    endtask

    task automatic test_reset_clear();
        int lo = 0;
        cfg_clear();
        c_mode[0] = 2'd0; c_mask[0] = 12'h001; c_str[0] = 8'd20;
        do_reset();
        step(12'h001);
        for (int i = 0; i < 5; i++) step('0);
        #1 check_cnt0("mid_pulse_pre", 1, 1, 0);
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (dout[0] !== 1'b0 || count_raw[31:0] !== 0 || count_acc[31:0] !== 0) begin
            n_fail++;
            $display("FAIL mid_pulse_reset: got dout=%b raw=%0d acc=%0d expected 0 0 0",
                     dout[0], count_raw[31:0], count_acc[31:0]);
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        c_str[0] = 8'd2;
        step(12'h001);
        step(12'h001, 1'b1);
        for (int i = 0; i < 5; i++) step('0);
        check_cnt0("reset_cnt_coincident", 0, 0, 0);

        c_mode[0] = 2'd1; c_mask[0] = '0;
        c_mode[1] = 2'd0; c_mask[1] = 12'h002; c_str[1] = 8'd2; c_inv[1] = 1'b1;
        do_reset();
        #1;
        n_checks++;
        if (dout[1] !== 1'b1) begin n_fail++; $display("FAIL invert_idle: got %b expected 1", dout[1]); end
        for (int i = 0; i < 30; i++) step(NI'($urandom));
        check_cnt0("and_mask0", 0, 0, 0);
        step('0); step('0);
        c_mode[0] = 2'd3;
        step(12'h002);
        for (int i = 0; i < 8; i++) begin
            step('0);
            #1 if (!dout[1]) lo++;
        end
        n_checks++;
        if (lo != 3) begin n_fail++; $display("FAIL invert_pulse: got %0d low cycles expected 3", lo); end
    endtask

    task automatic test_random();
        cfg_clear();
        for (int o = 0; o < NO; o++) begin
            c_mode[o] = 2'($urandom_range(0, 3));
            c_mask[o] = NI'($urandom);
            c_veto[o] = NI'($urandom & $urandom & $urandom);
            c_thr[o]  = 4'($urandom_range(0, 5));
            c_pre[o]  = 16'($urandom_range(0, 3));
            c_str[o]  = 8'($urandom_range(0, 5));
            c_dead[o] = 16'($urandom_range(0, 8));
            c_inv[o]  = 1'($urandom);
        end
        do_reset();
        for (int i = 0; i < 800; i++) begin
            step(NI'($urandom & $urandom), ($urandom_range(0, 60) == 0));
        end
        step('0);
        for (int o = 0; o < NO; o++) begin
            n_checks++;
            if (count_raw[o*32 +: 32] !== m_raw[o] || count_acc[o*32 +: 32] !== m_acc[o] ||
                count_lost[o*32 +: 32] !== m_lost[o]) begin
                n_fail++;
                $display("FAIL random_counts[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", o,
                         count_raw[o*32 +: 32], count_acc[o*32 +: 32], count_lost[o*32 +: 32],
                         m_raw[o], m_acc[o], m_lost[o]);
            end
        end
    endtask

    initial begin
        cyc = 0;
        cfg_clear();
        model_clear();
        test_reset();
        test_or_basic();
        test_majority();
        test_prescale();
        test_deadtime();
        test_veto();
        test_reset_clear();
        for (int r = 0; r < 4; r++) test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
